// File: rtl/lsu_dmem_if.sv
// Request/response handshake between the CPU pipeline and the load/store unit.
// The master modport is the CPU side; the slave modport is the LSU.
interface lsu_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_memop, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_memop, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32 load/store unit driving a word-addressed data memory port.
// Define MISALIGNED_EN to split word-crossing accesses over two memory cycles.
module lsu_dmem #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rstn,
    lsu_dmem_if.slave     bus,
    output logic [AW-1:0] dmem_rdaddress,
    output logic [AW-1:0] dmem_wraddress,
    output logic          dmem_wren,
    output logic [3:0]    dmem_byteena,
    output logic [31:0]   dmem_data,
    input  logic [31:0]   dmem_q
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    memop_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   w0_q;
    logic [AW-1:0] wordAddr_q, wordAddr_d;
    logic          reqErr;
    logic [31:0]   loadRaw, loadExt;

    function automatic logic [3:0] sizeMask(input logic [1:0] sz);
        case (sz)
            2'b00:   sizeMask = 4'b0001;
            2'b01:   sizeMask = 4'b0011;
            default: sizeMask = 4'b1111;
        endcase
    endfunction

    function automatic logic illegalOp(input logic we, input logic [2:0] memop);
        if (we) illegalOp = memop[2] | (memop[1:0] == 2'b11);
        else    illegalOp = (memop == 3'b011) | (memop[2:1] == 2'b11);
    endfunction

    // An access crosses into the next word when offset plus size exceeds four bytes.
    function automatic logic crossesWord(input logic [1:0] sz, input logic [1:0] off);
        crossesWord = ((sz == 2'b01) && (off == 2'b11)) || ((sz == 2'b10) && (off != 2'b00));
    endfunction

`ifdef MISALIGNED_EN
    logic [31:0] w1_q;
    logic [7:0]  laneMask;
    logic [63:0] laneData;

    assign reqErr   = illegalOp(bus.req_we, bus.req_memop);
    assign laneMask = {4'b0000, sizeMask(memop_q[1:0])} << addr_q[1:0];
    assign laneData = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign loadRaw  = 32'({w1_q, w0_q} >> {addr_q[1:0], 3'b000});
`else
    logic [3:0]  laneMask;
    logic [31:0] laneData;

    assign reqErr   = illegalOp(bus.req_we, bus.req_memop)
                    | crossesWord(bus.req_memop[1:0], bus.req_addr[1:0]);
    assign laneMask = sizeMask(memop_q[1:0]) << addr_q[1:0];
    assign laneData = wdata_q << {addr_q[1:0], 3'b000};
    assign loadRaw  = w0_q >> {addr_q[1:0], 3'b000};
`endif

    always_comb begin
        case (memop_q)
            3'b000:  loadExt = {{24{loadRaw[7]}}, loadRaw[7:0]};
            3'b001:  loadExt = {{16{loadRaw[15]}}, loadRaw[15:0]};
            3'b100:  loadExt = {24'b0, loadRaw[7:0]};
            3'b101:  loadExt = {16'b0, loadRaw[15:0]};
            default: loadExt = loadRaw;
        endcase
    end

    // The memory address is combinational so loads see dmem_q in the same ACC cycle.
    always_comb begin
        state_d        = state_q;
        wordAddr_d     = wordAddr_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'b0;
        bus.resp_err   = 1'b0;
        dmem_wren      = 1'b0;
        dmem_byteena   = 4'b0;
        dmem_data      = 32'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = reqErr ? RESP : ACC1;
            end
            ACC1: begin
                wordAddr_d = addr_q[AW+1:2];
                if (we_q) begin
                    dmem_wren    = 1'b1;
                    dmem_byteena = laneMask[3:0];
                    dmem_data    = laneData[31:0];
                end
`ifdef MISALIGNED_EN
                state_d = crossesWord(memop_q[1:0], addr_q[1:0]) ? ACC2 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef MISALIGNED_EN
            ACC2: begin
                wordAddr_d = addr_q[AW+1:2] + AW'(1);
                if (we_q) begin
                    dmem_wren    = 1'b1;
                    dmem_byteena = laneMask[7:4];
                    dmem_data    = laneData[63:32];
                end
                state_d = RESP;
            end
`endif
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || we_q) ? 32'b0 : loadExt;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_rdaddress = wordAddr_d;
    assign dmem_wraddress = wordAddr_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            memop_q    <= 3'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            err_q      <= 1'b0;
            w0_q       <= 32'b0;
`ifdef MISALIGNED_EN
            w1_q       <= 32'b0;
`endif
            wordAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            wordAddr_q <= wordAddr_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                memop_q <= bus.req_memop;
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
                err_q   <= reqErr;
            end
            if (state_q == ACC1 && !we_q) w0_q <= dmem_q;
`ifdef MISALIGNED_EN
            if (state_q == ACC2 && !we_q) w1_q <= dmem_q;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Randomized self-checking bench for lsu_dmem against a byte-addressed memory model.
// Expectations follow MISALIGNED_EN the same way the design does.
module tb_lsu_dmem;
    localparam int AW    = 15;
    localparam int WORDS = 1 << AW;
`ifdef MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic [AW-1:0] dmem_rdaddress, dmem_wraddress;
    logic          dmem_wren;
    logic [3:0]    dmem_byteena;
    logic [31:0]   dmem_data, dmem_q;

    lsu_dmem_if bus ();

    lsu_dmem #(.AW(AW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .dmem_rdaddress(dmem_rdaddress), .dmem_wraddress(dmem_wraddress),
        .dmem_wren(dmem_wren), .dmem_byteena(dmem_byteena),
        .dmem_data(dmem_data), .dmem_q(dmem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory; the backdoor port preloads words while the LSU is idle.
    logic [31:0]   mem [0:WORDS-1];
    logic          bdWe;
    logic [AW-1:0] bdAddr;
    logic [31:0]   bdData;
    int            wrenCycles;

    assign dmem_q = mem[dmem_rdaddress];

    always @(posedge clk) begin
        if (bdWe) mem[bdAddr] <= bdData;
        if (dmem_wren) begin
            wrenCycles++;
            for (int b = 0; b < 4; b++)
                if (dmem_byteena[b]) mem[dmem_wraddress][8*b +: 8] <= dmem_data[8*b +: 8];
        end
    end

    logic [7:0]    refMem [0:4*WORDS-1];
    int            checkCount, passCount;
    logic [31:0]   gotData, obsData1, obsData2;
    logic          gotErr;
    int            gotLat;
    logic [3:0]    obsEna1, obsEna2;
    logic [AW-1:0] obsAddr1, obsAddr2;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int sizeOf(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic int byteIdx(input logic [31:0] a);
        return int'(a[AW+1:0]);
    endfunction

    function automatic logic [31:0] refWord(input int w);
        return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] memop, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'b0;
        for (int i = 0; i < sizeOf(memop[1:0]); i++)
            v = v | (32'(refMem[byteIdx(addr + 32'(i))]) << (8*i));
        case (memop)
            3'b000:  v = {{24{v[7]}}, v[7:0]};
            3'b001:  v = {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    task automatic refStore(input logic [2:0] memop, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] sh;
        for (int i = 0; i < sizeOf(memop[1:0]); i++) begin
            sh = wdata >> (8*i);
            refMem[byteIdx(addr + 32'(i))] = sh[7:0];
        end
    endtask

    function automatic logic isIllegal(input logic we, input logic [2:0] memop);
        if (we) return (memop >= 3'd3);
        return (memop == 3'd3) || (memop == 3'd6) || (memop == 3'd7);
    endfunction

    task automatic setWord(input int w, input logic [31:0] v);
        @(negedge clk);
        bdWe = 1'b1; bdAddr = AW'(w); bdData = v;
        @(posedge clk);
        #1 bdWe = 1'b0;
        for (int b = 0; b < 4; b++) refMem[4*w+b] = v[8*b +: 8];
    endtask

    // Issues one request and records the response and the first two memory cycles.
    task automatic applyStimulus(input logic we, input logic [2:0] memop,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        checkOutput("idleReady", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("singlePulse", {31'b0, bus.resp_valid}, 32'd0);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_memop = memop;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        gotLat = 0; gotData = 32'b0; gotErr = 1'b0;
        obsEna1 = 4'b0; obsEna2 = 4'b0; obsAddr1 = '0; obsAddr2 = '0;
        obsData1 = 32'b0; obsData2 = 32'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k == 1) begin obsEna1 = dmem_byteena; obsAddr1 = dmem_wraddress; obsData1 = dmem_data; end
            if (k == 2) begin obsEna2 = dmem_byteena; obsAddr2 = dmem_wraddress; obsData2 = dmem_data; end
            if (bus.resp_valid) begin
                gotLat = k; gotData = bus.resp_rdata; gotErr = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic we, input logic [2:0] memop,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int          expLat, expWr, wrBefore;
        logic        crosses, expErr;
        logic [31:0] expData;
        crosses = (int'(addr[1:0]) + sizeOf(memop[1:0])) > 4;
        expErr  = isIllegal(we, memop) || (crosses && !MIS_EN);
        expLat  = expErr ? 1 : (crosses ? 3 : 2);
        expData = (expErr || we) ? 32'b0 : refLoad(memop, addr);
        expWr   = (we && !expErr) ? (crosses ? 2 : 1) : 0;
        wrBefore = wrenCycles;
        applyStimulus(we, memop, addr, wdata);
        checkOutput({tag, ".lat"}, 32'(gotLat), 32'(expLat));
        checkOutput({tag, ".err"}, {31'b0, gotErr}, {31'b0, expErr});
        checkOutput({tag, ".rdata"}, gotData, expData);
        checkOutput({tag, ".wren"}, 32'(wrenCycles - wrBefore), 32'(expWr));
        if (we && !expErr) refStore(memop, addr, wdata);
    endtask

    int          usedWords [8] = '{'h0, 'h1, 'h10, 'h11, 'h12, 'h13, 'h14, 'h7FFF};
    int          randWords [6] = '{'h0, 'h10, 'h11, 'h12, 'h13, 'h7FFF};
    logic [2:0]  storeOps  [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    int          pulses;

    initial begin
        checkCount = 0; passCount = 0; wrenCycles = 0;
        bdWe = 1'b0; bdAddr = '0; bdData = 32'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_memop = 3'b0;
        bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst.ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rst.respValid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("rst.rdata", bus.resp_rdata, 32'd0);
        checkOutput("rst.err", {31'b0, bus.resp_err}, 32'd0);
        checkOutput("rst.wren", {31'b0, dmem_wren}, 32'd0);
        checkOutput("rst.byteena", {28'b0, dmem_byteena}, 32'd0);
        checkOutput("rst.data", dmem_data, 32'd0);
        checkOutput("rst.rdaddr", 32'(dmem_rdaddress), 32'd0);
        checkOutput("rst.wraddr", 32'(dmem_wraddress), 32'd0);
        rstn = 1'b1;

        foreach (usedWords[i]) setWord(usedWords[i], $urandom());
        setWord('h10, 32'h8899AABB);
        setWord('h11, 32'h00000077);

        runAndCheck("lb", 1'b0, 3'b000, 32'h41, 32'h0);
        checkOutput("lb.const", gotData, 32'hFFFFFFAA);
        runAndCheck("lbu", 1'b0, 3'b100, 32'h41, 32'h0);
        checkOutput("lbu.const", gotData, 32'h000000AA);
        runAndCheck("lwMis", 1'b0, 3'b010, 32'h43, 32'h0);
        if (MIS_EN) checkOutput("lwMis.const", gotData, 32'h00007788);
        else        checkOutput("lwMis.errConst", {31'b0, gotErr}, 32'd1);
        runAndCheck("sh", 1'b1, 3'b001, 32'h42, 32'h00001234);
        checkOutput("sh.byteena", {28'b0, obsEna1}, 32'b1100);
        checkOutput("sh.data", obsData1, 32'h12340000);
        checkOutput("sh.word", 32'(obsAddr1), 32'h10);
        runAndCheck("lwAfterSh", 1'b0, 3'b010, 32'h40, 32'h0);
        checkOutput("lwAfterSh.const", gotData, 32'h1234AABB);
        runAndCheck("illegal", 1'b0, 3'b011, 32'h40, 32'h0);
        checkOutput("illegal.errConst", {31'b0, gotErr}, 32'd1);

        runAndCheck("swWrap", 1'b1, 3'b010, (32'h7FFF << 2) + 32'd2, 32'hDEADBEEF);
        if (MIS_EN) begin
            checkOutput("swWrap.ena1", {28'b0, obsEna1}, 32'b1100);
            checkOutput("swWrap.addr1", 32'(obsAddr1), 32'h7FFF);
            checkOutput("swWrap.data1", obsData1, 32'hBEEF0000);
            checkOutput("swWrap.ena2", {28'b0, obsEna2}, 32'b0011);
            checkOutput("swWrap.addr2", 32'(obsAddr2), 32'h0);
            checkOutput("swWrap.data2", obsData2, 32'h0000DEAD);
            checkOutput("swWrap.hiWord", {16'b0, mem['h7FFF][31:16]}, 32'hBEEF);
            checkOutput("swWrap.loWord", {16'b0, mem[0][15:0]}, 32'hDEAD);
        end else begin
            checkOutput("swWrap.errConst", {31'b0, gotErr}, 32'd1);
        end

        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [2:0]  op;
            logic [31:0] addr, upper;
            we    = 1'($urandom_range(0, 1));
            op    = we ? storeOps[$urandom_range(0, 6)] : 3'($urandom_range(0, 7));
            upper = $urandom();
            addr  = (upper & 32'hFFFE0000) | (32'(randWords[$urandom_range(0, 5)]) << 2)
                  | 32'($urandom_range(0, 3));
            runAndCheck("rand", we, op, addr, $urandom());
        end

        foreach (usedWords[i]) checkOutput("memImage", mem[usedWords[i]], refWord(usedWords[i]));

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_memop = 3'b010;
        bus.req_addr = 32'h50; bus.req_wdata = $urandom();
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("abort.wrenAcc1", {31'b0, dmem_wren}, 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("abort.wrenDrop", {31'b0, dmem_wren}, 32'd0);
        pulses = 0;
        repeat (3) begin @(negedge clk); if (bus.resp_valid) pulses++; end
        rstn = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.resp_valid) pulses++; end
        checkOutput("abort.noResp", 32'(pulses), 32'd0);
        checkOutput("abort.ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("abort.word", mem['h14], refWord('h14));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
